cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 33 +++
 rtl/cache_fill_fsm_if.sv | 35 +++
 rtl/cache_onehot_dec.sv | 15 +
 rtl/cache_fill_fsm.sv | 82 ++++++++
 tb/tb_cache_fill_fsm.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM state encoding, geometry and address field positions.
package cache_fill_fsm_pkg;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int NUM_WORDS = 8;
   localparam int NUM_SETS  = 64;
   localparam int CNT_W     = 4;

   localparam int TAG_MSB  = 15;
   localparam int TAG_LSB  = 10;
   localparam int SET_MSB  = 9;
   localparam int SET_LSB  = 4;
   localparam int WORD_MSB = 3;
   localparam int WORD_LSB = 1;

   localparam int TAG_W  = TAG_MSB - TAG_LSB + 1;
   localparam int SET_W  = SET_MSB - SET_LSB + 1;
   localparam int WORD_W = WORD_MSB - WORD_LSB + 1;

   localparam logic [ADDR_W-1:0] LINE_OFFSET_MASK = ADDR_W'((1 << SET_LSB) - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_t;

   // Address of the first byte of the line containing addr.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
      line_base = addr & ~LINE_OFFSET_MASK;
   endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/memory/data-array signal bundle between the pipeline, memory and the fill FSM.
interface cache_fill_fsm_if;
   import cache_fill_fsm_pkg::*;

   logic                 miss_detected;
   logic [ADDR_W-1:0]    miss_address;
   logic                 victim_way;
   logic [DATA_W-1:0]    memory_data;
   logic                 memory_data_valid;

   logic                 fsm_busy;
   logic                 mem_read_en;
   logic [ADDR_W-1:0]    mem_addr;
   logic                 data_wen_w1;
   logic                 data_wen_w2;
   logic [NUM_SETS-1:0]  block_enable;
   logic [NUM_WORDS-1:0] word_enable;
   logic [DATA_W-1:0]    fill_data;
   logic                 tag_wen_w1;
   logic                 tag_wen_w2;
   logic [TAG_W-1:0]     fill_tag;

   modport master (
      output miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
      input  fsm_busy, mem_read_en, mem_addr, data_wen_w1, data_wen_w2, block_enable,
             word_enable, fill_data, tag_wen_w1, tag_wen_w2, fill_tag
   );

   modport slave (
      input  miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
      output fsm_busy, mem_read_en, mem_addr, data_wen_w1, data_wen_w2, block_enable,
             word_enable, fill_data, tag_wen_w1, tag_wen_w2, fill_tag
   );

endinterface

// File: rtl/cache_onehot_dec.sv
// Generic N-to-2^N one-hot decoder; the output is all zero when not enabled.
module cache_onehot_dec #(
   parameter int N = 3
) (
   input  logic [N-1:0]      i_sel,
   input  logic              i_en,
   output logic [(1<<N)-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_sel] = 1'b1;
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: issues 8 in-order word reads for a missed line and
// writes the returned words, then the tag, into the victim way.
module cache_fill_fsm
   import cache_fill_fsm_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   cache_fill_fsm_if.slave bus
);

   fill_state_t       r_state;
   logic [ADDR_W-1:0] r_base;
   logic              r_way;
   logic [CNT_W-1:0]  r_issue_cnt;
   logic [CNT_W-1:0]  r_recv_cnt;

   logic                 w_fill;
   logic                 w_issue;
   logic                 w_write;
   logic                 w_last;
   logic [NUM_SETS-1:0]  w_block_oh;
   logic [NUM_WORDS-1:0] w_word_oh;

   assign w_fill  = (r_state == ST_FILL);
   assign w_issue = w_fill && (r_issue_cnt < CNT_W'(NUM_WORDS));
   // Completion is driven purely by returned valids, so memory latency is irrelevant.
   assign w_write = w_fill && bus.memory_data_valid && (r_recv_cnt < CNT_W'(NUM_WORDS));
   assign w_last  = w_write && (r_recv_cnt == CNT_W'(NUM_WORDS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_base      <= '0;
         r_way       <= 1'b0;
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.miss_detected) begin
                  r_base      <= line_base(bus.miss_address);
                  r_way       <= bus.victim_way;
                  r_issue_cnt <= '0;
                  r_recv_cnt  <= '0;
                  r_state     <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
               if (w_write) r_recv_cnt  <= r_recv_cnt + CNT_W'(1);
               if (w_last)  r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   cache_onehot_dec #(.N(SET_W)) u_block_dec (
      .i_sel    (r_base[SET_MSB:SET_LSB]),
      .i_en     (w_write),
      .o_onehot (w_block_oh)
   );

   cache_onehot_dec #(.N(WORD_W)) u_word_dec (
      .i_sel    (r_recv_cnt[WORD_W-1:0]),
      .i_en     (w_write),
      .o_onehot (w_word_oh)
   );

   assign bus.fsm_busy     = w_fill;
   assign bus.mem_read_en  = w_issue;
   assign bus.mem_addr     = w_issue ? (r_base + {{(ADDR_W-CNT_W-1){1'b0}}, r_issue_cnt, 1'b0}) : '0;
   assign bus.data_wen_w1  = w_write & ~r_way;
   assign bus.data_wen_w2  = w_write &  r_way;
   assign bus.block_enable = w_block_oh;
   assign bus.word_enable  = w_word_oh;
   assign bus.fill_data    = w_write ? bus.memory_data : '0;
   assign bus.tag_wen_w1   = w_last & ~r_way;
   assign bus.tag_wen_w2   = w_last &  r_way;
   assign bus.fill_tag     = w_last ? r_base[TAG_MSB:TAG_LSB] : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a line-level reference model queues expected
// requests and array writes; a negedge monitor compares whatever the DUT presents.
module tb_cache_fill_fsm;
   import cache_fill_fsm_pkg::*;

   typedef struct {
      logic       way;
      logic [5:0] set;
      logic [2:0] word;
      logic [15:0] data;
      logic       last;
      logic [5:0] tag;
   } wr_t;

   typedef struct {
      logic [15:0] data;
      int          ready;
   } mreq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cache_fill_fsm_if bus ();

   cache_fill_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          mcyc    = 0;
   int          next_ok = 0;
   bit          gap_mode   = 1'b0;
   bit          idle_noise = 1'b0;
   bit          model_busy = 1'b0;
   int          busy_run      = 0;
   int          last_busy_run = 0;
   int          last_req_cyc  = 0;
   logic [15:0] salt = 16'h0000;

   logic [15:0] exp_req[$];
   wr_t         exp_wr[$];
   mreq_t       mem_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   // Memory contents as seen by the fill: a fixed scramble of the word address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0] ^ 8'h5A, a[15:8] + 8'h33} ^ salt;
   endfunction

   // Memory: answers requests in order after their latency, optionally with gaps.
   initial begin
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         mcyc++;
         bus.memory_data_valid = 1'b0;
         bus.memory_data       = 16'h0;
         if (mem_q.size() > 0 && mem_q[0].ready <= mcyc && mcyc >= next_ok) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = mem_q[0].data;
            void'(mem_q.pop_front());
            next_ok = gap_mode ? mcyc + 1 + int'($urandom_range(1, 3)) : 0;
         end else if (idle_noise) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = 16'($urandom);
         end
      end
   end

   // Monitor: captures memory requests and checks every output each cycle.
   initial begin
      wr_t e;
      int  lat;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("reset_ctrl_outputs", 64'({bus.fsm_busy, bus.mem_read_en, bus.data_wen_w1,
                bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2}), 64'd0);
            chk("reset_data_outputs", 64'({bus.mem_addr, bus.word_enable, bus.fill_data,
                bus.fill_tag}), 64'd0);
            chk("reset_block_enable", bus.block_enable, 64'd0);
         end else begin
            busy_run = bus.fsm_busy ? busy_run + 1 : 0;
            chk("fsm_busy", 64'(bus.fsm_busy), 64'(model_busy));
            chk("both_ways", 64'((bus.data_wen_w1 | bus.tag_wen_w1) & (bus.data_wen_w2 | bus.tag_wen_w2)), 64'd0);
            if (bus.mem_read_en) begin
               lat = gap_mode ? int'($urandom_range(1, 4)) : 4;
               mem_q.push_back('{data: mem_word(bus.mem_addr), ready: mcyc + lat});
               if (exp_req.size() == 0) begin
                  chk("unexpected_req", 64'(bus.mem_addr), 64'hFFFF_FFFF);
               end else begin
                  if (exp_req.size() < NUM_WORDS) chk("req_consecutive", 64'(mcyc), 64'(last_req_cyc + 1));
                  chk("mem_addr", 64'(bus.mem_addr), 64'(exp_req.pop_front()));
               end
               last_req_cyc = mcyc;
            end else begin
               chk("mem_addr_idle", 64'(bus.mem_addr), 64'd0);
            end
            if (bus.data_wen_w1 || bus.data_wen_w2) begin
               if (exp_wr.size() == 0) begin
                  chk("unexpected_write", 64'd1, 64'd0);
               end else begin
                  e = exp_wr.pop_front();
                  chk("data_wen_way", 64'({bus.data_wen_w2, bus.data_wen_w1}), e.way ? 64'd2 : 64'd1);
                  chk("block_enable", bus.block_enable, 64'd1 << e.set);
                  chk("word_enable", 64'(bus.word_enable), 64'd1 << e.word);
                  chk("fill_data", 64'(bus.fill_data), 64'(e.data));
                  chk("tag_wen", 64'({bus.tag_wen_w2, bus.tag_wen_w1}),
                      e.last ? (e.way ? 64'd2 : 64'd1) : 64'd0);
                  chk("fill_tag", 64'(bus.fill_tag), e.last ? 64'(e.tag) : 64'd0);
                  if (e.last) begin
                     last_busy_run = busy_run;
                     model_busy    = 1'b0;
                  end
               end
            end else begin
               chk("no_write_block", bus.block_enable, 64'd0);
               chk("no_write_misc", 64'({bus.tag_wen_w2, bus.tag_wen_w1, bus.word_enable,
                   bus.fill_data, bus.fill_tag}), 64'd0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done();
      int t = 0;
      while (model_busy && t < 400) begin
         tick();
         t++;
      end
      if (model_busy) timeout_fail("fill_done");
   endtask

   // Reference model: a miss fetches the 8 words of its line in address order.
   task automatic start_fill(input logic [15:0] addr, input logic way, input bit early);
      int          t;
      int          base;
      wr_t         w;
      if (early) begin
         t = 0;
         while (exp_wr.size() > 1 && t < 400) begin
            tick();
            t++;
         end
         bus.miss_detected = 1'b1;
         bus.miss_address  = addr;
         bus.victim_way    = way;
      end
      wait_done();
      salt              = 16'($urandom);
      idle_noise        = 1'b0;
      bus.miss_detected = 1'b1;
      bus.miss_address  = addr;
      bus.victim_way    = way;
      base = (int'(addr) / 16) * 16;
      for (int k = 0; k < NUM_WORDS; k++) begin
         exp_req.push_back(16'(base + 2 * k));
         w.way  = way;
         w.set  = 6'((int'(addr) / 16) % 64);
         w.word = 3'(k);
         w.data = mem_word(16'(base + 2 * k));
         w.last = (k == NUM_WORDS - 1);
         w.tag  = 6'(int'(addr) / 1024);
         exp_wr.push_back(w);
      end
      tick();
      model_busy        = 1'b1;
      bus.miss_detected = 1'b0;
   endtask

   task automatic fill_with_stray_misses(input logic [15:0] addr, input logic way);
      int t = 0;
      start_fill(addr, way, 1'b0);
      while (exp_wr.size() > 2 && t < 400) begin
         bus.miss_detected = 1'($urandom);
         bus.miss_address  = 16'($urandom);
         bus.victim_way    = 1'($urandom);
         tick();
         t++;
      end
      bus.miss_detected = 1'b0;
      wait_done();
   endtask

   initial begin
      int t;
      bus.miss_detected = 1'b0;
      bus.miss_address  = 16'h0;
      bus.victim_way    = 1'b0;
      #3 rst = 1'b0;
      #3;
      chk("reset_busy", 64'(bus.fsm_busy), 64'd0);
      chk("reset_read_en", 64'(bus.mem_read_en), 64'd0);
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();

      gap_mode = 1'b0;
      start_fill(16'h1234, 1'b0, 1'b0);
      wait_done();
      chk("busy_cycles_w1", 64'(last_busy_run), 64'd12);

      start_fill(16'h1234, 1'b1, 1'b0);
      wait_done();
      chk("busy_cycles_w2", 64'(last_busy_run), 64'd12);

      idle_noise = 1'b1;
      repeat (10) tick();
      idle_noise = 1'b0;
      repeat (2) tick();

      gap_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) begin
            start_fill(16'($urandom), 1'($urandom), 1'b0);
            wait_done();
         end else begin
            fill_with_stray_misses(16'($urandom), 1'($urandom));
         end
      end

      gap_mode = 1'b0;
      start_fill(16'($urandom), 1'b0, 1'b0);
      start_fill(16'($urandom), 1'b1, 1'b1);
      wait_done();

      start_fill(16'hBEEF, 1'b1, 1'b0);
      t = 0;
      while (exp_wr.size() > 5 && t < 100) begin
         tick();
         t++;
      end
      if (exp_wr.size() > 5) timeout_fail("three_words");
      rst = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(bus.fsm_busy), 64'd0);
      chk("rst_mid_wen", 64'({bus.data_wen_w1, bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2}), 64'd0);
      chk("rst_mid_read", 64'({bus.mem_read_en, bus.mem_addr}), 64'd0);
      exp_req.delete();
      exp_wr.delete();
      model_busy = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (20) tick();
      start_fill(16'hBEEF, 1'b1, 1'b0);
      wait_done();
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
